// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and message geometry.
package spi_pkg;

   localparam int SPI_MAX_DATA_BYTES = 8;
   localparam int SPI_CMD_WIDTH      = 8;
   localparam int SPI_DATA_WIDTH     = SPI_MAX_DATA_BYTES * 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CMD     = 2'd1,
      ST_DATA    = 2'd2,
      ST_DISCARD = 2'd3
   } spi_state_t;

   // True once the command byte has been fully received in this message.
   function automatic logic past_cmd(input spi_state_t s);
      return (s == ST_DATA) || (s == ST_DISCARD);
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Per-signal synchronizer with rise/fall detection on the synchronized value.
// Edges are masked until the pipeline has been refilled after reset, so a line
// that sits away from its idle level across reset never produces a false edge.
module spi_sync #(
   parameter int   STAGES     = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] pipe;
   logic              prev;
   logic [STAGES:0]   fill;

   // Synchronizer chain, edge-history flop and post-reset fill tracker.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe <= {STAGES{IDLE_LEVEL}};
         prev <= IDLE_LEVEL;
         fill <= '0;
      end else begin
         pipe <= {pipe[STAGES-2:0], din};
         prev <= pipe[STAGES-1];
         fill <= {fill[STAGES-1:0], 1'b1};
      end
   end

   assign level = pipe[STAGES-1];
   assign rise  = fill[STAGES] &  level & ~prev;
   assign fall  = fill[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: one command byte followed by up to eight data bytes.
// Optional reply path enabled by defining SPI_SLAVE_TX_EN.
//
// Handshake: there is no valid/ready pair; spi_msg_end is a one-cycle
// strobe and spi_cmd/spi_rxdata are valid and stable while it is high.
// spi_txdata is sampled only in the cycle the command byte completes,
// qualified by spi_txdata_valid.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      spi_ssel_n,
   input  logic                      spi_sclk,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   output logic                      spi_msg_end,
   output logic [SPI_CMD_WIDTH-1:0]  spi_cmd,
   output logic [SPI_DATA_WIDTH-1:0] spi_rxdata,
   input  logic [SPI_DATA_WIDTH-1:0] spi_txdata,
   input  logic                      spi_txdata_valid
);

   logic ssel_level, ssel_rise, ssel_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   // ssel_n is synchronized as-is, so its fall is the start of a message.
   spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ssel (
      .clk(clk), .reset(reset), .din(spi_ssel_n),
      .level(ssel_level), .rise(ssel_rise), .fall(ssel_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .din(spi_sclk),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(spi_mosi),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   spi_state_t                state;
   logic [7:0]                shift_reg;
   logic [2:0]                bit_cnt;
   logic [3:0]                byte_cnt;
   logic [SPI_CMD_WIDTH-1:0]  cmd_r;
   logic [SPI_DATA_WIDTH-1:0] rxdata_r;
   logic                      msg_end_r;

   logic [7:0] next_byte;
   logic       bit_take;
   logic       cmd_done;

   assign next_byte = {shift_reg[6:0], mosi_level};
   // ssel edges take priority over any sclk edge seen in the same cycle.
   assign bit_take  = sclk_rise && !ssel_rise && !ssel_fall && (state != ST_IDLE);
   assign cmd_done  = bit_take && (state == ST_CMD) && (bit_cnt == 3'd7);

   // Message FSM, bit/byte assembly and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         cmd_r     <= '0;
         rxdata_r  <= '0;
         msg_end_r <= 1'b0;
      end else begin
         msg_end_r <= 1'b0;
         if (ssel_rise) begin
            msg_end_r <= past_cmd(state);
            state     <= ST_IDLE;
         end else if (ssel_fall) begin
            state     <= ST_CMD;
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rxdata_r  <= '0;
         end else if (bit_take) begin
            shift_reg <= next_byte;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               case (state)
                  ST_CMD: begin
                     cmd_r <= next_byte;
                     state <= ST_DATA;
                  end
                  ST_DATA: begin
                     for (int k = 0; k < SPI_MAX_DATA_BYTES; k++) begin
                        if (byte_cnt == 4'(k)) rxdata_r[SPI_DATA_WIDTH-1-8*k -: 8] <= next_byte;
                     end
                     byte_cnt <= byte_cnt + 4'd1;
                     if (byte_cnt == 4'(SPI_MAX_DATA_BYTES - 1)) state <= ST_DISCARD;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign spi_msg_end = msg_end_r;
   assign spi_cmd     = cmd_r;
   assign spi_rxdata  = rxdata_r;

`ifdef SPI_SLAVE_TX_EN
   logic [SPI_DATA_WIDTH-1:0] tx_shift;
   logic                      tx_step;

   // The fall right after the command byte must not shift: the MSB has to be
   // presented for the first data rise. Later falls follow a taken data bit.
   assign tx_step = sclk_fall && !ssel_rise && !ssel_fall && past_cmd(state) &&
                    ((bit_cnt != 3'd0) || (byte_cnt != 4'd0));

   // Reply shift register: loaded when the command completes, zero-filled.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_shift <= '0;
      end else if (ssel_rise || ssel_fall) begin
         tx_shift <= '0;
      end else if (cmd_done) begin
         tx_shift <= spi_txdata_valid ? spi_txdata : '0;
      end else if (tx_step) begin
         tx_shift <= {tx_shift[SPI_DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign spi_miso = tx_shift[SPI_DATA_WIDTH-1];

   logic unused_sync;
   assign unused_sync = ^{ssel_level, sclk_level, mosi_rise, mosi_fall};
`else
   assign spi_miso = 1'b0;

   logic unused_sync;
   assign unused_sync = ^{ssel_level, sclk_level, sclk_fall, mosi_rise, mosi_fall,
                          cmd_done, spi_txdata, spi_txdata_valid};
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed scenarios plus random messages
// compared against a message-level model of the decoded outputs.
module tb_spi_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        spi_ssel_n = 1'b1;
   logic        spi_sclk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic        spi_msg_end;
   logic [7:0]  spi_cmd;
   logic [63:0] spi_rxdata;
   logic [63:0] spi_txdata = '0;
   logic        spi_txdata_valid = 1'b0;

   int checks = 0;
   int failures = 0;

   // message bytes to send, captured MISO bytes, expected MISO bytes
   logic [7:0] msg_q[$];
   logic [7:0] miso_q[$];
   logic [7:0] exp_q[$];

   int          pulse_cnt = 0;
   logic [7:0]  cap_cmd = '0;
   logic [63:0] cap_rx = '0;
   logic [7:0]  exp_cmd = '0;
   logic [63:0] exp_rx;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .spi_ssel_n(spi_ssel_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_msg_end(spi_msg_end),
      .spi_cmd(spi_cmd), .spi_rxdata(spi_rxdata),
      .spi_txdata(spi_txdata), .spi_txdata_valid(spi_txdata_valid)
   );

   // clock / global time limit
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time limit (checks=%0d)", checks);
      $fatal(1, "timeout");
   end

   // pulse monitor: counts strobes and captures outputs while strobe is high
   always @(negedge clk) begin
      if (spi_msg_end) begin
         pulse_cnt = pulse_cnt + 1;
         cap_cmd   = spi_cmd;
         cap_rx    = spi_rxdata;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic spi_begin(input int half);
      @(negedge clk);
      spi_ssel_n = 1'b0;
      repeat (half) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [7:0] b, input int nbits, input int half,
                           output logic [7:0] mb);
      mb = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_mosi = b[i];
         repeat (half) @(negedge clk);
         mb[i] = spi_miso;
         spi_sclk = 1'b1;
         repeat (half) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic spi_end();
      repeat (4) @(negedge clk);
      spi_ssel_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // sends msg_q as whole bytes plus an optional partial trailing byte
   task automatic send_msg(input int half, input int trail_n, input logic [7:0] trail_b);
      logic [7:0] mb;
      miso_q.delete();
      spi_begin(half);
      foreach (msg_q[i]) begin
         spi_bits(msg_q[i], 8, half, mb);
         miso_q.push_back(mb);
      end
      if (trail_n > 0) spi_bits(trail_b, trail_n, half, mb);
      spi_end();
   endtask

   // ---------------- reference model ----------------
   // Byte 0 is the command; bytes 1..8 fill rxdata from the top; the rest vanish.
   task automatic model_msg();
      exp_rx = '0;
      if (msg_q.size() >= 1) exp_cmd = msg_q[0];
      for (int k = 1; k < msg_q.size() && k <= 8; k++)
         exp_rx[63 - 8*(k-1) -: 8] = msg_q[k];
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (spi_msg_end !== 1'b0) begin failures++; $display("FAIL reset_msg_end: got %b want 0", spi_msg_end); end
      checks++; if (spi_cmd !== 8'h00) begin failures++; $display("FAIL reset_cmd: got %h want 00", spi_cmd); end
      checks++; if (spi_rxdata !== 64'h0) begin failures++; $display("FAIL reset_rxdata: got %h want 0", spi_rxdata); end
      checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      pulse_cnt = 0;
      msg_q = '{8'h01, 8'h02};
      model_msg();
      send_msg(6, 0, 8'h00);
      checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL basic_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (spi_cmd !== 8'h01) begin failures++; $display("FAIL basic_cmd: got %h want 01", spi_cmd); end
      checks++; if (spi_rxdata !== 64'h0200000000000000) begin failures++; $display("FAIL basic_rxdata: got %h want 0200000000000000", spi_rxdata); end
      checks++; if (cap_rx !== exp_rx) begin failures++; $display("FAIL basic_rx_at_pulse: got %h want %h", cap_rx, exp_rx); end
   endtask

   task automatic test_overflow();
      pulse_cnt = 0;
      msg_q = '{8'h10, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hAA};
      model_msg();
      send_msg(5, 0, 8'h00);
      checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL ovf_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (spi_cmd !== exp_cmd) begin failures++; $display("FAIL ovf_cmd: got %h want %h", spi_cmd, exp_cmd); end
      checks++; if (spi_rxdata !== 64'hFEFFFFFFFFFFFF7F) begin failures++; $display("FAIL ovf_rxdata: got %h want FEFFFFFFFFFFFF7F", spi_rxdata); end
   endtask

   task automatic test_partial();
      logic [7:0] mb;
      pulse_cnt = 0;
      spi_begin(5);
      spi_bits(8'($urandom), 5, 5, mb);
      spi_end();
      checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL partial_no_pulse: got %0d want 0", pulse_cnt); end
      msg_q = '{8'h12, 8'h41};
      model_msg();
      send_msg(5, 0, 8'h00);
      checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL partial_next_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (spi_cmd !== 8'h12) begin failures++; $display("FAIL partial_next_cmd: got %h want 12", spi_cmd); end
      checks++; if (spi_rxdata[63:56] !== 8'h41) begin failures++; $display("FAIL partial_next_byte0: got %h want 41", spi_rxdata[63:56]); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] mb;
      pulse_cnt = 0;
      spi_begin(5);
      spi_bits(8'h10, 8, 5, mb);
      spi_bits(8'h55, 8, 5, mb);
      spi_bits(8'h77, 3, 5, mb);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++; if (spi_cmd !== 8'h00 || spi_rxdata !== 64'h0 || spi_miso !== 1'b0) begin
         failures++; $display("FAIL midreset_outputs: cmd %h rx %h miso %b want all 0", spi_cmd, spi_rxdata, spi_miso); end
      spi_bits(8'h88, 8, 5, mb);
      spi_bits(8'h99, 8, 5, mb);
      spi_end();
      checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL midreset_no_pulse: got %0d want 0", pulse_cnt); end
      checks++; if (spi_cmd !== 8'h00 || spi_rxdata !== 64'h0) begin
         failures++; $display("FAIL midreset_ignored: cmd %h rx %h want 00/0", spi_cmd, spi_rxdata); end
      exp_cmd = 8'h00;
      msg_q = '{8'hA5, 8'h3C, 8'h96};
      model_msg();
      send_msg(5, 0, 8'h00);
      checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL midreset_clean_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (spi_cmd !== exp_cmd || spi_rxdata !== exp_rx) begin
         failures++; $display("FAIL midreset_clean_data: cmd %h rx %h want %h %h", spi_cmd, spi_rxdata, exp_cmd, exp_rx); end
   endtask

   task automatic test_coincident();
      logic [7:0] mb;
      logic [7:0] last_b;
      pulse_cnt = 0;
      last_b = 8'hC3;
      msg_q = '{8'h33, 8'h5A};
      model_msg();
      spi_begin(4);
      spi_bits(8'h33, 8, 4, mb);
      spi_bits(8'h5A, 8, 4, mb);
      spi_bits(last_b, 7, 4, mb);
      spi_mosi = last_b[0];
      repeat (4) @(negedge clk);
      spi_sclk = 1'b1;
      spi_ssel_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (12) @(negedge clk);
      checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL coinc_pulses: got %0d want 1", pulse_cnt); end
      checks++; if (spi_rxdata !== exp_rx) begin failures++; $display("FAIL coinc_rxdata: got %h want %h", spi_rxdata, exp_rx); end
      checks++; if (spi_cmd !== 8'h33) begin failures++; $display("FAIL coinc_cmd: got %h want 33", spi_cmd); end
   endtask

   task automatic test_random();
      int len, half, trail;
      for (int n = 0; n < 8; n++) begin
         pulse_cnt = 0;
         len   = $urandom_range(1, 10);
         half  = $urandom_range(4, 8);
         trail = $urandom_range(0, 7);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         model_msg();
         send_msg(half, trail, 8'($urandom));
         checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL rand%0d_pulses: got %0d want 1", n, pulse_cnt); end
         checks++; if (spi_cmd !== exp_cmd || cap_cmd !== exp_cmd) begin
            failures++; $display("FAIL rand%0d_cmd: got %h (at pulse %h) want %h", n, spi_cmd, cap_cmd, exp_cmd); end
         checks++; if (spi_rxdata !== exp_rx || cap_rx !== exp_rx) begin
            failures++; $display("FAIL rand%0d_rxdata: got %h (at pulse %h) want %h", n, spi_rxdata, cap_rx, exp_rx); end
      end
   endtask

   task automatic test_miso();
      for (int v = 1; v >= 0; v--) begin
         spi_txdata       = 64'h8123456789ABCDEF;
         spi_txdata_valid = v[0];
         msg_q.delete();
         msg_q.push_back(8'h20);
         for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom));
         exp_q.delete();
         exp_q.push_back(8'h00);
         for (int k = 0; k < 8; k++) begin
`ifdef SPI_SLAVE_TX_EN
            exp_q.push_back(v[0] ? spi_txdata[63 - 8*k -: 8] : 8'h00);
`else
            exp_q.push_back(8'h00);
`endif
         end
         send_msg(8, 0, 8'h00);
         for (int k = 0; k < 9; k++) begin
            checks++; if (miso_q[k] !== exp_q[k]) begin
               failures++; $display("FAIL miso_v%0d_byte%0d: got %h want %h", v, k, miso_q[k], exp_q[k]); end
         end
      end
      spi_txdata_valid = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_partial();
      test_reset_mid();
      test_coincident();
      test_random();
      test_miso();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, synchronizer depth for spi_ssel_n/spi_sclk/spi_mosi (legal range 2..3).
REQ-002 The block SHALL have port clk, input, 1, system clock (one clock; all logic on rising edge).
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port spi_ssel_n, input, 1, async chip select, active low.
REQ-005 The block SHALL have port spi_sclk, input, 1, async SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 The block SHALL have port spi_mosi, input, 1, async master-out data, MSB first.
REQ-007 The block SHALL have port spi_miso, output, 1, slave-out data, MSB first.
REQ-008 The block SHALL have port spi_msg_end, output, 1, one-cycle pulse at message end.
REQ-009 The block SHALL have port spi_cmd, output, 8, command byte of current/last message.
REQ-010 The block SHALL have port spi_rxdata, output, 64, data bytes; byte k at [63-8k -: 8].
REQ-011 The block SHALL have port spi_txdata, input, 64, reply data from register stage.
REQ-012 The block SHALL have port spi_txdata_valid, input, 1, spi_txdata holds a reply.

Function
REQ-013 Inputs SHALL pass SYNC_STAGES flops; sclk rise/fall and ssel fall/rise SHALL be edge-detected on synchronized values; clk SHALL be at least 8x sclk.
REQ-014 States: IDLE, CMD, DATA, DISCARD; IDLE->CMD on ssel fall; CMD->DATA after 8th bit; DATA->DISCARD after 8th data byte; any state->IDLE on ssel rise.
REQ-015 On ssel fall, spi_rxdata SHALL clear to 0, bit counter (3 bits) and byte counter (4 bits) to 0.
REQ-016 Each synchronized sclk rise SHALL shift mosi into an 8-bit shift register; bits arriving while in IDLE SHALL be ignored.
REQ-017 On 8th bit in CMD, spi_cmd SHALL update the cycle after; it SHALL otherwise hold until the next command byte.
REQ-018 On 8th bit of data byte k (k<8), that byte SHALL be written to spi_rxdata[63-8k -: 8] the cycle after; bytes beyond 8 SHALL be discarded without change.
REQ-019 On ssel rise, spi_msg_end SHALL pulse for exactly one cycle, one cycle after edge detection, only if a full command byte was received; partial trailing bytes SHALL be dropped.
REQ-020 spi_cmd and spi_rxdata SHALL be stable while spi_msg_end is high.
REQ-021 Simultaneous ssel rise and sclk rise in the same cycle: ssel rise SHALL win; that bit is dropped.
REQ-022 spi_miso SHALL be 0 in IDLE and during the command byte.

Reset
REQ-023 On reset: state IDLE, spi_msg_end 0, spi_cmd 8'h00, spi_rxdata 0, spi_miso 0, counters and shift registers 0, synchronizers to idle levels (ssel_n=1, sclk=0).
REQ-024 Reset mid-message SHALL abort it with no spi_msg_end; remaining bits SHALL be ignored until the next ssel fall.

Configuration
REQ-025 Macro SPI_SLAVE_TX_EN: when defined, spi_txdata SHALL be latched into a 64-bit tx shift register the cycle after the command byte completes if spi_txdata_valid=1 (else 0), and its MSB SHALL be driven on spi_miso, shifting on each sclk fall in DATA; 0 after 64 bits.
REQ-026 Without SPI_SLAVE_TX_EN, spi_miso SHALL be constant 0 and spi_txdata/spi_txdata_valid unused.

Structure
REQ-027 Shared package spi_pkg SHALL hold state encodings, SPI_MAX_DATA_BYTES=8 and SPI_CMD_WIDTH=8.
REQ-028 Sub-module spi_sync SHALL implement the per-signal synchronizer plus rise/fall detect, instantiated three times.

Verification
REQ-029 Send 01h,02h -> one spi_msg_end pulse, spi_cmd=01h, spi_rxdata=64'h0200000000000000.
REQ-030 Send 10h + FE,FF,FF,FF,FF,FF,FF,7F,AA -> spi_rxdata=64'hFEFFFFFFFFFFFF7F, AA discarded, one pulse.
REQ-031 ssel low, 5 sclk pulses, ssel high -> no spi_msg_end; next 12h,41h -> spi_cmd=12h, spi_rxdata[63:56]=41h.
REQ-032 Assert reset after cmd byte 10h mid-data -> all outputs 0, no pulse; next clean message decodes normally.
REQ-033 SPI_SLAVE_TX_EN, txdata=64'h8123456789ABCDEF valid=1, cmd + 8 dummy bytes -> MISO bytes 81,23,45,67,89,AB,CD,EF; valid=0 -> all 00.
REQ-034 sclk at clk/8 with ssel rise coincident with a sclk rise -> last bit dropped, msg_end pulse once.
